// File: rtl/matrix_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_cfg_pkg
//  Description : Shared types and sizing helpers for the switch-matrix
//                configuration loader (state enum, default geometry,
//                frame length and bit-counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_cfg_pkg;

    // Default matrix geometry; 2**SEL_W must exceed NUM_WIRES
    localparam int c_default_num_wires = 18;
    localparam int c_default_sel_w     = 5;

    // Loader states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Number of select bits in one frame, excluding any parity bit
    function automatic int frame_bits(input int num_wires, input int sel_w);
        return num_wires * sel_w;
    endfunction

    // Counter width with headroom for the optional parity bit
    function automatic int cnt_width(input int num_wires, input int sel_w);
        return $clog2(frame_bits(num_wires, sel_w) + 2);
    endfunction

endpackage : matrix_cfg_pkg
`default_nettype wire

// File: rtl/matrix_cfg_field_chk.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_cfg_field_chk
//  Description : Combinational per-wire field checker. Flags a fault when any
//                select field points past the last wire or selects its own
//                wire (self-drive). Mutual selection between two wires is
//                legal and deliberately not flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_cfg_field_chk
    import matrix_cfg_pkg::*;
#(
    parameter int NUM_WIRES = c_default_num_wires,
    parameter int SEL_W     = c_default_sel_w
) (
    input  logic [NUM_WIRES*SEL_W-1:0] shadow,
    output logic                       fault
);

    logic [NUM_WIRES-1:0] w_field_bad;

    // One range/self-drive comparator per wire; wire k is 1-based
    generate
        for (genvar k = 1; k <= NUM_WIRES; k++) begin : g_field
            logic [SEL_W-1:0] w_sel;
            assign w_sel            = shadow[k*SEL_W-1 -: SEL_W];
            assign w_field_bad[k-1] = (w_sel > SEL_W'(NUM_WIRES)) ||
                                      (w_sel == SEL_W'(k));
        end
    endgenerate

    assign fault = |w_field_bad;

endmodule : matrix_cfg_field_chk
`default_nettype wire

// File: rtl/matrix_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_cfg_loader
//  Description : Serial configuration loader for the switch matrix. Shifts a
//                frame in MSB first (wire NUM_WIRES first), validates every
//                select field, then commits all selects to sel_flat in one
//                edge. sel_flat never exposes a partially received frame.
//                Optional macro CFG_PARITY_EN appends one even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_cfg_loader
    import matrix_cfg_pkg::*;
#(
    parameter int NUM_WIRES = c_default_num_wires,
    parameter int SEL_W     = c_default_sel_w
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_valid,
    input  logic                       cfg_bit,
    output logic                       cfg_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [NUM_WIRES*SEL_W-1:0] sel_flat
);

    localparam int c_frame_bits = frame_bits(NUM_WIRES, SEL_W);
    localparam int c_cnt_w      = cnt_width(NUM_WIRES, SEL_W);
`ifdef CFG_PARITY_EN
    localparam int c_frame_len  = c_frame_bits + 1;
`else
    localparam int c_frame_len  = c_frame_bits;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_frame_len-1:0]  r_shadow;
    logic [c_frame_bits-1:0] r_sel;
    logic                    r_done;
    logic                    r_err;

    logic [c_frame_bits-1:0] w_data;
    logic                    w_parity_ok;
    logic                    w_field_fault;
    logic                    w_frame_ok;
    logic                    w_accept;
    logic                    w_last_bit;
    logic                    w_restart;

    // A start pulse in SHIFT wins over a bit presented in the same cycle
    assign w_accept   = cfg_valid & cfg_ready & ~cfg_start;
    assign w_last_bit = w_accept && (r_cnt == c_cnt_w'(c_frame_len - 1));
    assign w_restart  = cfg_start && (r_state != ST_CHECK);

`ifdef CFG_PARITY_EN
    // Parity bit arrives last, so it sits in the shadow LSB
    assign w_data      = r_shadow[c_frame_len-1:1];
    assign w_parity_ok = ~(^r_shadow);
`else
    assign w_data      = r_shadow;
    assign w_parity_ok = 1'b1;
`endif

    matrix_cfg_field_chk #(
        .NUM_WIRES (NUM_WIRES),
        .SEL_W     (SEL_W)
    ) u_field_chk (
        .shadow (w_data),
        .fault  (w_field_fault)
    );

    assign w_frame_ok = w_parity_ok & ~w_field_fault;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is ignored while CHECK resolves the frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: if (cfg_start) w_state_nxt = ST_SHIFT;
            ST_SHIFT:        if (w_last_bit) w_state_nxt = ST_CHECK;
            ST_CHECK:        w_state_nxt = w_frame_ok ? ST_IDLE : ST_ERR;
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake/status outputs decoded purely from the registered state
    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
            end
            ST_CHECK: busy = 1'b1;
            default: begin
                cfg_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Bit counter and shadow shift register; start discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else if (w_restart) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else if (w_accept) begin
            r_cnt    <= r_cnt + c_cnt_w'(1);
            r_shadow <= {r_shadow[c_frame_len-2:0], cfg_bit};
        end
    end

    // Atomic commit, done pulse and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_CHECK) begin
                if (w_frame_ok) begin
                    r_sel  <= w_data;
                    r_done <= 1'b1;
                end else begin
                    r_err  <= 1'b1;
                end
            end else if (cfg_start) begin
                r_err <= 1'b0;
            end
        end
    end

    assign sel_flat = r_sel;
    assign done     = r_done;
    assign err      = r_err;

endmodule : matrix_cfg_loader
`default_nettype wire

// File: tb/tb_matrix_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_cfg_loader
//  Description : Self-checking bench for matrix_cfg_loader. Frames are built
//                from per-wire select values; expected outputs follow the
//                frame timeline and are compared every cycle on the falling
//                edge. Honours CFG_PARITY_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_cfg_loader;

    localparam int NW = 18;
    localparam int SW = 5;
    localparam int FB = NW * SW;
`ifdef CFG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = FB + PAR;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_bit;
    logic          cfg_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [FB-1:0] sel_flat;

    always #5 clk = ~clk;

    matrix_cfg_loader #(
        .NUM_WIRES (NW),
        .SEL_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sel_flat  (sel_flat)
    );

    // Reference expectations
    logic [FB-1:0] exp_sel;
    logic          exp_ready;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_err;
    bit            chk_en = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Compare all outputs each cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("sel_flat",  sel_flat,       exp_sel);
            check("cfg_ready", FB'(cfg_ready), FB'(exp_ready));
            check("busy",      FB'(busy),      FB'(exp_busy));
            check("done",      FB'(done),      FB'(exp_done));
            check("err",       FB'(err),       FB'(exp_err));
        end
    end

    // Place wire k's select at bits [k*SW-1 -: SW]
    function automatic logic [FB-1:0] pack(input int f[NW+1]);
        logic [FB-1:0] v;
        v = '0;
        for (int k = 1; k <= NW; k++) v[k*SW-1 -: SW] = SW'(f[k]);
        return v;
    endfunction

    // A frame is acceptable when no select is out of range or self-driving
    function automatic bit fields_ok(input int f[NW+1]);
        for (int k = 1; k <= NW; k++) begin
            if (f[k] > NW || f[k] == k) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [FL-1:0] rand_bits();
        logic [FL-1:0] v;
        for (int i = 0; i < FL; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        rst       = 1'b1;
        tick();
        exp_sel   = '0;
        exp_ready = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        chk_en    = 1'b1;
        for (int i = 1; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic start_frame();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        exp_ready = 1'b1;
        exp_busy  = 1'b1;
        exp_err   = 1'b0;
    endtask

    // gaps: 0 none, 1 idle cycle before every bit, 2 random idle cycles
    task automatic shift_bits(input logic [FL-1:0] fr, input int n, input int gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 3) == 0)) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom);
                tick();
            end
            cfg_valid = 1'b1;
            cfg_bit   = fr[FL-1-i];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic restart_frame();
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'($urandom);
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic run_frame(input int f[NW+1], input bit flip, input int gaps,
                             input int restart_at, input bit start_in_check,
                             input bit extra_valid);
        logic [FB-1:0] d;
        logic [FL-1:0] fr;
        bit            ok;
        d = pack(f);
`ifdef CFG_PARITY_EN
        fr = {d, (^d) ^ flip};
`else
        fr = d;
`endif
        ok = fields_ok(f) && !(flip && PAR == 1);
        start_frame();
        if (restart_at >= 0) begin
            shift_bits(rand_bits(), restart_at, gaps);
            restart_frame();
        end
        shift_bits(fr, FL, gaps);
        // CHECK cycle: no bit may be taken, start is ignored
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
        cfg_valid = extra_valid;
        cfg_bit   = 1'b1;
        cfg_start = start_in_check;
        tick();
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        exp_busy  = 1'b0;
        if (ok) begin
            exp_sel  = d;
            exp_done = 1'b1;
        end else begin
            exp_err  = 1'b1;
        end
        tick();
        exp_done = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g[NW+1];
        int h[NW+1];
        logic [FB-1:0] pv;

        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        rst       = 1'b1;
        do_reset(2);
        tick();

        // Reference frame: wire1=2, wire2=3, wire18=1
        g = '{default: 0};
        g[1]  = 2;
        g[2]  = 3;
        g[18] = 1;
        pv = pack(g);
        check("model pack wire1",  FB'(pv[4:0]),   FB'(2));
        check("model pack wire2",  FB'(pv[9:5]),   FB'(3));
        check("model pack wire18", FB'(pv[89:85]), FB'(1));
        check("model ok good",     FB'(fields_ok(g)), FB'(1));

        run_frame(g, 1'b0, 0, -1, 1'b0, 1'b0);
        check("lit sel wire1",  FB'(sel_flat[4:0]),   FB'(2));
        check("lit sel wire2",  FB'(sel_flat[9:5]),   FB'(3));
        check("lit sel wire18", FB'(sel_flat[89:85]), FB'(1));
        check("lit sel others", FB'(sel_flat[84:10]), FB'(0));

        // Self-drive on wire 5
        h = g;
        h[5] = 5;
        check("model ok selfdrive", FB'(fields_ok(h)), FB'(0));
        run_frame(h, 1'b0, 0, -1, 1'b0, 1'b0);
        check("lit err selfdrive",  FB'(err), FB'(1));
        check("lit sel kept",       FB'(sel_flat[9:0]), FB'(10'h062));

        // A good frame clears err and commits
        h = g;
        h[3] = 4;
        run_frame(h, 1'b0, 0, -1, 1'b0, 1'b0);
        check("lit err cleared", FB'(err), FB'(0));
        check("lit sel wire3",   FB'(sel_flat[14:10]), FB'(4));

        // Range faults on wire 7
        h = g;
        h[7] = 19;
        check("model ok range19", FB'(fields_ok(h)), FB'(0));
        run_frame(h, 1'b0, 0, -1, 1'b0, 1'b0);
        h[7] = 31;
        run_frame(h, 1'b0, 0, -1, 1'b0, 1'b0);

        // Handshake gaps every other cycle
        run_frame(g, 1'b0, 1, -1, 1'b0, 1'b0);

        // Restart after 40 bits, only the second frame commits
        h = g;
        h[10] = 11;
        run_frame(h, 1'b0, 0, 40, 1'b0, 1'b0);

        // Trailing valid in CHECK must not be taken; start in CHECK ignored
        run_frame(g, 1'b0, 0, -1, 1'b1, 1'b1);
        tick();

`ifdef CFG_PARITY_EN
        run_frame(g, 1'b1, 0, -1, 1'b0, 1'b0);
`endif

        // Reset during SHIFT after 30 bits clears the committed selects
        start_frame();
        shift_bits(rand_bits(), 30, 0);
        do_reset(2);
        tick();

        // Randomised frames
        for (int n = 0; n < 30; n++) begin
            for (int k = 1; k <= NW; k++) begin
                h[k] = int'($urandom_range(0, NW));
                if (h[k] == k) h[k] = 0;
            end
            h[0] = 0;
            if ($urandom_range(0, 3) == 0) begin
                int k = int'($urandom_range(1, NW));
                h[k] = ($urandom_range(0, 1) == 0) ? k : int'($urandom_range(NW + 1, 31));
            end
            run_frame(h,
                      1'(PAR == 1 && $urandom_range(0, 5) == 0),
                      int'($urandom_range(0, 2)),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FL - 1)) : -1,
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_matrix_cfg_loader
`default_nettype wire
